nios_ii_debug_adc_sequencer: RTL and testbench

NIOS_II_DEBUG_ADC_SEQUENCER -- requirements
Module: nios_ii_debug_adc_sequencer

---
 rtl/nios_ii_debug_adc_sequencer.sv | 104 ++++++++++
 tb/tb_nios_ii_debug_adc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_debug_adc_sequencer.sv
// nios_ii_debug_adc_sequencer: round-robin SPI sequencer for an 8-channel serial ADC with an address pipeline and sample strobes
`timescale 1ns/1ps
module nios_ii_debug_adc_sequencer #(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_channel,
  output logic        sample_valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, FRAME, GAP} state_t;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  state_t state, state_nx;
  logic [7:0] div_cnt, mask, new_mask;
  logic [3:0] bit_cnt, rem, new_rem;
  logic [2:0] addr, prev_addr;
  logic [11:0] shift;
  logic phase, priming, div_end, frame_end, sweep_done;
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] a);
    logic [2:0] r;
    r = a;
    for (int i = 7; i >= 1; i--)
      if (m[3'(a + 3'(i))]) r = 3'(a + 3'(i));
    return r;
  endfunction
  always_comb begin
    new_mask   = ch_mask == 8'h00 ? 8'h01 : ch_mask;
    new_rem    = 4'($countones(new_mask));
    div_end    = div_cnt == DIV_LAST;
    frame_end  = state == FRAME && div_end && phase && bit_cnt == 4'd15;
    sweep_done = frame_end && !priming && rem == 4'd1;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE  ? ((start || continuous) ? SETUP : IDLE) :
               state == SETUP ? (div_end ? FRAME : SETUP) :
               state == FRAME ? ((sweep_done && !continuous) ? GAP : FRAME) :
                                (div_end ? IDLE : GAP);
  end
  always_comb begin
    busy     = state != IDLE;
    adc_cs_n = state == IDLE || state == GAP;
    adc_sclk = state != FRAME || phase;
    adc_din  = state == FRAME && (bit_cnt == 4'd2 ? addr[2] :
                                  bit_cnt == 4'd3 ? addr[1] :
                                  bit_cnt == 4'd4 ? addr[0] : 1'b0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt        <= '0;
      bit_cnt        <= '0;
      phase          <= 1'b0;
      mask           <= '0;
      rem            <= '0;
      addr           <= '0;
      prev_addr      <= '0;
      priming        <= 1'b0;
      shift          <= '0;
      sample_data    <= '0;
      sample_channel <= '0;
      sample_valid   <= 1'b0;
    end else begin
      div_cnt      <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
      sample_valid <= frame_end && !priming;
      if (state == FRAME && div_end) begin
        phase <= !phase;
        if (phase) bit_cnt <= bit_cnt + 4'd1;
        else if (bit_cnt >= 4'd4) shift <= {shift[10:0], adc_dout};
      end
      if (state == IDLE && (start || continuous)) begin
        mask    <= new_mask;
        rem     <= new_rem;
        addr    <= next_ch(new_mask, 3'd7);
        priming <= 1'b1;
      end
      if (frame_end) begin
        prev_addr <= addr;
        priming   <= 1'b0;
        if (!priming) begin
          sample_data    <= shift;
          sample_channel <= prev_addr;
        end
        if (sweep_done) begin
          mask <= new_mask;
          rem  <= new_rem;
          addr <= next_ch(new_mask, addr);
        end else begin
          rem  <= priming ? rem : rem - 4'd1;
          addr <= next_ch(mask, addr);
        end
      end
    end
  end
endmodule

// File: tb/tb_nios_ii_debug_adc_sequencer.sv
// tb_nios_ii_debug_adc_sequencer: directed self-checking bench with a serial ADC model
`timescale 1ns/1ps
module tb_nios_ii_debug_adc_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, continuous = 1'b0, adc_dout = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic adc_cs_n, adc_sclk, adc_din, sample_valid, busy;
  logic [11:0] sample_data;
  logic [2:0] sample_channel;
  int asserts = 0, fails = 0;
  nios_ii_debug_adc_sequencer #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample_data(sample_data), .sample_channel(sample_channel),
    .sample_valid(sample_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  int fb = -1, frames = 0, n_sent = 0;
  logic [2:0] conv_ch = 3'd0, addr_rx = 3'd0;
  logic [11:0] word;
  logic [2:0] sent_log [256];
  always @(negedge adc_sclk or posedge adc_cs_n) begin
    if (adc_cs_n) begin
      fb = -1;
      adc_dout = 1'b0;
    end else begin
      fb = (fb + 1) % 16;
      if (fb == 0) frames++;
      word = 12'hA00 + {9'd0, conv_ch};
      adc_dout = 1'b0;
      if (fb >= 4) adc_dout = word[15 - fb];
    end
  end
  always @(posedge adc_sclk) begin
    if (!adc_cs_n && fb >= 2 && fb <= 4) begin
      addr_rx = {addr_rx[1:0], adc_din};
      if (fb == 4 && n_sent < 256) begin
        sent_log[n_sent] = addr_rx;
        n_sent++;
      end
    end
    if (!adc_cs_n && fb == 15) conv_ch = addr_rx;
  end
  int cyc = 0;
  always @(posedge clk) cyc++;
  logic [2:0] st_ch [256];
  logic [11:0] st_data [256];
  int n_st = 0, din_bad = 0, per_bad = 0, cs_rise = 0, last_fall = -1;
  bit chk_period = 1'b0;
  logic prev_sclk = 1'b1, prev_din = 1'b0, prev_cs = 1'b1;
  always @(negedge clk) begin
    if (sample_valid && n_st < 256) begin
      st_ch[n_st] = sample_channel;
      st_data[n_st] = sample_data;
      n_st++;
    end
    if (adc_din !== prev_din && !(prev_sclk && !adc_sclk)) din_bad++;
    if (adc_cs_n && !prev_cs) cs_rise++;
    if (adc_cs_n) last_fall = -1;
    else if (prev_sclk && !adc_sclk) begin
      if (chk_period && last_fall >= 0 && cyc - last_fall != 4) per_bad++;
      last_fall = cyc;
    end
    prev_sclk = adc_sclk;
    prev_din = adc_din;
    prev_cs = adc_cs_n;
  end
  task automatic pulse_start(input logic [7:0] m);
    @(negedge clk);
    ch_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(output int bc, output bit to);
    bc = 0;
    while (busy && bc < 5000) begin
      bc++;
      @(negedge clk);
    end
    to = busy;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    asserts++;
    if ({adc_cs_n, adc_sclk, adc_din, busy, sample_valid} !== 5'b11000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 11000", {adc_cs_n, adc_sclk, adc_din, busy, sample_valid});
    end
    asserts++;
    if ({sample_channel, sample_data} !== 15'd0) begin
      fails++;
      $display("FAIL reset_sample: got ch %0d data %h expected 0/000", sample_channel, sample_data);
    end
    reset = 1'b0;
  endtask
  task automatic test_single_sweep;
    int bs, bn, bc;
    bit to;
    bs = n_st;
    bn = n_sent;
    pulse_start(8'h05);
    wait_idle(bc, to);
    asserts++;
    if (to || bc != 196) begin
      fails++;
      $display("FAIL single_busy: got %0d cycles (timeout %0d) expected 196", bc, to);
    end
    asserts++;
    if (n_st - bs != 2) begin
      fails++;
      $display("FAIL single_strobes: got %0d expected 2", n_st - bs);
    end
    asserts++;
    if ({st_ch[bs], st_data[bs], st_ch[bs+1], st_data[bs+1]} !== {3'd0, 12'hA00, 3'd2, 12'hA02}) begin
      fails++;
      $display("FAIL single_data: got %0d/%h %0d/%h expected 0/a00 2/a02", st_ch[bs], st_data[bs], st_ch[bs+1], st_data[bs+1]);
    end
    asserts++;
    if (n_sent - bn != 3 || {sent_log[bn], sent_log[bn+1], sent_log[bn+2]} !== {3'd0, 3'd2, 3'd0}) begin
      fails++;
      $display("FAIL single_addr: got %0d frames %0d,%0d,%0d expected 3 frames 0,2,0", n_sent - bn, sent_log[bn], sent_log[bn+1], sent_log[bn+2]);
    end
    asserts++;
    if (adc_cs_n !== 1'b1) begin
      fails++;
      $display("FAIL single_cs_end: got %b expected 1", adc_cs_n);
    end
  endtask
  task automatic test_zero_mask;
    int bs, bc;
    bit to;
    bs = n_st;
    pulse_start(8'h00);
    wait_idle(bc, to);
    asserts++;
    if (to || bc != 132) begin
      fails++;
      $display("FAIL zero_busy: got %0d cycles expected 132", bc);
    end
    asserts++;
    if (n_st - bs != 1 || st_ch[bs] !== 3'd0 || st_data[bs] !== 12'hA00) begin
      fails++;
      $display("FAIL zero_strobe: got %0d strobes ch %0d data %h expected 1 ch 0 data a00", n_st - bs, st_ch[bs], st_data[bs]);
    end
  endtask
  task automatic test_continuous;
    int bs, bcs, bp, n, bc;
    bit to;
    logic [2:0] ech;
    bs = n_st;
    bcs = cs_rise;
    bp = per_bad;
    chk_period = 1'b1;
    @(negedge clk);
    ch_mask = 8'h81;
    continuous = 1'b1;
    n = 0;
    while (n_st - bs < 5 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    asserts++;
    if (n_st - bs < 5) begin
      fails++;
      $display("FAIL cont_wait: got %0d strobes expected 5 before timeout", n_st - bs);
    end
    wait_idle(bc, to);
    chk_period = 1'b0;
    asserts++;
    if (to || n_st - bs != 6) begin
      fails++;
      $display("FAIL cont_strobes: got %0d expected 6", n_st - bs);
    end
    for (int k = 0; k < 6; k++) begin
      ech = (k % 2 == 0) ? 3'd0 : 3'd7;
      asserts++;
      if (st_ch[bs+k] !== ech || st_data[bs+k] !== 12'hA00 + {9'd0, ech}) begin
        fails++;
        $display("FAIL cont_seq%0d: got ch %0d data %h expected ch %0d", k, st_ch[bs+k], st_data[bs+k], ech);
      end
    end
    asserts++;
    if (cs_rise - bcs != 1) begin
      fails++;
      $display("FAIL cont_cs_low: got %0d cs_n rises expected 1", cs_rise - bcs);
    end
    asserts++;
    if (per_bad != bp) begin
      fails++;
      $display("FAIL cont_sclk_period: got %0d bad periods expected 0", per_bad - bp);
    end
  endtask
  task automatic test_reset_mid_frame;
    int bs, bf, n, bc;
    bit to;
    bs = n_st;
    bf = frames;
    pulse_start(8'h03);
    n = 0;
    while (!(frames - bf == 2 && fb == 8) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    asserts++;
    if (frames - bf != 2 || fb != 8) begin
      fails++;
      $display("FAIL rst_reach_bit8: got frame %0d bit %0d expected frame 2 bit 8", frames - bf, fb);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    asserts++;
    if ({adc_cs_n, adc_sclk, busy, sample_valid} !== 4'b1100) begin
      fails++;
      $display("FAIL rst_mid_ctrl: got %b expected 1100", {adc_cs_n, adc_sclk, busy, sample_valid});
    end
    asserts++;
    if ({sample_channel, sample_data} !== 15'd0) begin
      fails++;
      $display("FAIL rst_mid_sample: got ch %0d data %h expected 0/000", sample_channel, sample_data);
    end
    repeat (50) @(negedge clk);
    asserts++;
    if (n_st != bs) begin
      fails++;
      $display("FAIL rst_no_strobe: got %0d strobes expected 0", n_st - bs);
    end
    pulse_start(8'h01);
    wait_idle(bc, to);
    asserts++;
    if (to || bc != 132) begin
      fails++;
      $display("FAIL rst_priming: got %0d busy cycles expected 132", bc);
    end
    asserts++;
    if (n_st - bs != 1 || st_ch[bs] !== 3'd0 || st_data[bs] !== 12'hA00) begin
      fails++;
      $display("FAIL rst_after_strobe: got %0d strobes ch %0d data %h expected 1 ch 0 data a00", n_st - bs, st_ch[bs], st_data[bs]);
    end
  endtask
  task automatic test_busy_start_mask_change;
    int bs, bn, n, bc;
    bit to;
    bs = n_st;
    bn = n_sent;
    pulse_start(8'h05);
    n = 0;
    while (fb != 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ch_mask = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(bc, to);
    asserts++;
    if (to || n_st - bs != 2 || st_ch[bs] !== 3'd0 || st_ch[bs+1] !== 3'd2) begin
      fails++;
      $display("FAIL busy_old_mask: got %0d strobes ch %0d,%0d expected 2 ch 0,2", n_st - bs, st_ch[bs], st_ch[bs+1]);
    end
    asserts++;
    if (n_sent - bn != 3) begin
      fails++;
      $display("FAIL busy_no_extra: got %0d frames expected 3", n_sent - bn);
    end
    bs = n_st;
    bn = n_sent;
    pulse_start(8'h02);
    wait_idle(bc, to);
    asserts++;
    if (to || n_st - bs != 1 || st_ch[bs] !== 3'd1 || st_data[bs] !== 12'hA01) begin
      fails++;
      $display("FAIL new_mask_strobe: got %0d strobes ch %0d data %h expected 1 ch 1 data a01", n_st - bs, st_ch[bs], st_data[bs]);
    end
    asserts++;
    if (n_sent - bn != 2 || sent_log[bn] !== 3'd1 || sent_log[bn+1] !== 3'd1) begin
      fails++;
      $display("FAIL new_mask_addr: got %0d frames %0d,%0d expected 2 frames 1,1", n_sent - bn, sent_log[bn], sent_log[bn+1]);
    end
  endtask
  task automatic test_din_timing;
    asserts++;
    if (din_bad != 0) begin
      fails++;
      $display("FAIL din_timing: got %0d off-edge din changes expected 0", din_bad);
    end
    asserts++;
    if (sample_data[11] !== 1'b1 || sample_data !== 12'hA01) begin
      fails++;
      $display("FAIL dout_capture: got %h expected a01", sample_data);
    end
  endtask
  initial begin
    test_reset;
    test_single_sweep;
    test_zero_mask;
    test_continuous;
    test_reset_mid_frame;
    test_busy_start_mask_change;
    test_din_timing;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
